// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit that initiates accesses on a word-addressed data
// memory and adds byte/halfword access on top of it. Sub-word loads are
// extracted from the read word and sign- or zero-extended. Sub-word stores
// are done as read-modify-write.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   reqValid/reqReady    request handshake from the memory stage
//   reqWrite, reqSize,   request attributes: store flag, size (00 byte,
//   reqSigned, reqAddr,  01 half, 10 word, 11 illegal), load extension,
//   reqWdata             byte address, right-justified store data
//   respValid            one-cycle completion pulse
//   respData, respErr    load result (0 for stores/errors), error flag
//   memAddr              word-aligned address to dmem
//   memWriteEnable       dmem write strobe
//   memWriteData         full word written to dmem
//   memReadData          combinational dmem read data
module dmem_lsu #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         reqValid,
  output logic         reqReady,
  input  logic         reqWrite,
  input  logic [1:0]   reqSize,
  input  logic         reqSigned,
  input  logic [n-1:0] reqAddr,
  input  logic [n-1:0] reqWdata,
  output logic         respValid,
  output logic [n-1:0] respData,
  output logic         respErr,
  output logic [n-1:0] memAddr,
  output logic         memWriteEnable,
  output logic [n-1:0] memWriteData,
  input  logic [n-1:0] memReadData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t         state_q, state_d;
  logic           write_q, write_d;
  logic [1:0]     size_q, size_d;
  logic           signed_q, signed_d;
  // Only the lane offset and the low halfword of the store data are needed
  // after acceptance; the aligned address and full store word go straight
  // into the memory-side registers.
  logic [1:0]     lane_q, lane_d;
  logic [15:0]    wdata_lo_q, wdata_lo_d;
  logic [n-1:0]   resp_data_q, resp_data_d;
  logic           resp_err_q, resp_err_d;
  logic [n-1:0]   mem_addr_q, mem_addr_d;
  logic [n-1:0]   mem_wdata_q, mem_wdata_d;

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_bad = 1'b0;
      2'b01:   is_bad = a[0];
      2'b10:   is_bad = (a != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [n-1:0] load_extract(input logic [n-1:0] word,
                                                input logic [1:0]   size,
                                                input logic         sgn,
                                                input logic [1:0]   a);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extract = {{(n-8){sgn & b[7]}}, b};
      2'b01:   load_extract = {{(n-16){sgn & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [n-1:0] store_merge(input logic [n-1:0] word,
                                               input logic [1:0]   size,
                                               input logic [1:0]   a,
                                               input logic [15:0]  wd);
    logic [n-1:0] m;
    m = word;
    if (size == 2'b00) m[{a, 3'b000} +: 8]     = wd[7:0];
    else               m[{a[1], 4'b0000} +: 16] = wd;
    store_merge = m;
  endfunction

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    wdata_lo_d  = wdata_lo_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          write_d    = reqWrite;
          size_d     = reqSize;
          signed_d   = reqSigned;
          lane_d     = reqAddr[1:0];
          wdata_lo_d = reqWdata[15:0];
          if (is_bad(reqSize, reqAddr[1:0])) begin
            // No memory access at all: memAddr keeps its previous value.
            resp_err_d  = 1'b1;
            resp_data_d = '0;
            state_d     = RESP;
          end else if (reqWrite && reqSize == 2'b10) begin
            mem_addr_d  = {reqAddr[n-1:2], 2'b00};
            mem_wdata_d = reqWdata;
            state_d     = WRITE;
          end else begin
            mem_addr_d = {reqAddr[n-1:2], 2'b00};
            state_d    = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_wdata_d = store_merge(memReadData, size_q, lane_q, wdata_lo_q);
          state_d     = WRITE;
        end else begin
          resp_data_d = load_extract(memReadData, size_q, signed_q, lane_q);
          resp_err_d  = 1'b0;
          state_d     = RESP;
        end
      end
      WRITE: begin
        resp_data_d = '0;
        resp_err_d  = 1'b0;
        state_d     = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      wdata_lo_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      wdata_lo_q  <= wdata_lo_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // All outputs come from registered state, so the async reset drops the
  // write strobe immediately.
  assign reqReady       = (state_q == IDLE);
  assign respValid      = (state_q == RESP);
  assign memWriteEnable = (state_q == WRITE);
  assign respData       = resp_data_q;
  assign respErr        = resp_err_q;
  assign memAddr        = mem_addr_q;
  assign memWriteData   = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu with a behavioural word memory.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqSigned = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        respValid;
  logic [31:0] respData;
  logic        respErr;
  logic [31:0] memAddr;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  logic [31:0] mem [0:255];
  logic [32:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.n(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr),
    .reqWdata(reqWdata), .respValid(respValid), .respData(respData),
    .respErr(respErr), .memAddr(memAddr), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  assign memReadData = mem[memAddr[9:2]];

  // Word memory: preload, then write on the rising edge while enabled.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h54 >> 2] = 32'h0000_0000;
    mem[8'hA8 >> 2] = 32'hACAC_AC80;
    mem[8'hFC >> 2] = 32'hBCBC_BCBC;
    mem[8'h40 >> 2] = 32'h2222_2222;
    forever begin
      @(posedge clk);
      if (memWriteEnable) mem[memAddr[9:2]] = memWriteData;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // Response side of the scoreboard.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && respValid) begin
      check("resp_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_err", {31'b0, respErr}, {31'b0, e[32]});
        check("resp_data", respData, e[31:0]);
      end
    end
  end

  // Issue one request, push its expected response, and track latency and
  // write strobes until respValid. Called at #1 after a rising edge.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e,
                        input int exp_lat, input int exp_we,
                        input logic [31:0] exp_wd);
    int guard;
    int lat;
    int we;
    bit done;
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_wait", {31'b0, reqReady}, 1);
    reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWdata = wd;
    reqValid = 1'b1;
    exp_q.push_back({exp_e, exp_d});
    @(posedge clk); #1;
    reqValid = 1'b0;
    lat = 1; we = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      check("busy_ready", {31'b0, reqReady}, 0);
      if (memWriteEnable) begin
        we++;
        check("wr_addr", memAddr, {a[31:2], 2'b00});
        check("wr_data", memWriteData, exp_wd);
      end
      if (respValid) done = 1'b1;
      else if (lat >= 6) done = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check("latency", lat, exp_lat);
    check("we_count", we, exp_we);
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    check("rst_ready", {31'b0, reqReady}, 1);
    check("rst_resp_valid", {31'b0, respValid}, 0);
    check("rst_resp_err", {31'b0, respErr}, 0);
    check("rst_we", {31'b0, memWriteEnable}, 0);
    check("rst_resp_data", respData, 0);
    check("rst_mem_addr", memAddr, 0);
    check("rst_mem_wdata", memWriteData, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then word load.
    do_req(1, 2'b10, 0, 32'h54, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF);
    do_req(0, 2'b10, 0, 32'h54, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0);

    // Sub-word loads from 0xACACAC80.
    do_req(0, 2'b00, 1, 32'hA8, 32'h0, 32'hFFFFFF80, 0, 2, 0, 32'h0);
    do_req(0, 2'b00, 0, 32'hA8, 32'h0, 32'h00000080, 0, 2, 0, 32'h0);
    do_req(0, 2'b01, 0, 32'hAA, 32'h0, 32'h0000ACAC, 0, 2, 0, 32'h0);
    do_req(0, 2'b01, 1, 32'hAA, 32'h0, 32'hFFFFACAC, 0, 2, 0, 32'h0);
    do_req(0, 2'b00, 1, 32'hAB, 32'h0, 32'hFFFFFFAC, 0, 2, 0, 32'h0);

    // Read-modify-write stores.
    do_req(1, 2'b00, 0, 32'hFE, 32'h12345611, 32'h0, 0, 3, 1, 32'hBC11BCBC);
    do_req(0, 2'b10, 0, 32'hFC, 32'h0, 32'hBC11BCBC, 0, 2, 0, 32'h0);
    do_req(1, 2'b01, 0, 32'hFE, 32'hAAAA9999, 32'h0, 0, 3, 1, 32'h9999BCBC);
    do_req(0, 2'b10, 0, 32'hFC, 32'h0, 32'h9999BCBC, 0, 2, 0, 32'h0);

    // Misaligned and illegal requests.
    do_req(0, 2'b10, 0, 32'h55, 32'h0, 32'h0, 1, 1, 0, 32'h0);
    do_req(1, 2'b01, 0, 32'h57, 32'hFFFF5555, 32'h0, 1, 1, 0, 32'h0);
    check("mis_store_mem", mem[8'h54 >> 2], 32'hDEADBEEF);
    do_req(0, 2'b11, 0, 32'h40, 32'h0, 32'h0, 1, 1, 0, 32'h0);

    // Reset during the write cycle of a word store.
    reqWrite = 1; reqSize = 2'b10; reqAddr = 32'h40; reqWdata = 32'h11111111;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    check("rst_mid_we_on", {31'b0, memWriteEnable}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_we_off", {31'b0, memWriteEnable}, 0);
    check("rst_mid_ready", {31'b0, reqReady}, 1);
    check("rst_mid_resp", {31'b0, respValid}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_mem", mem[8'h40 >> 2], 32'h22222222);
    @(posedge clk); #1;
    check("rst_mid_no_resp", {31'b0, respValid}, 0);
    check("rst_mid_ready2", {31'b0, reqReady}, 1);
    do_req(0, 2'b10, 0, 32'h40, 32'h0, 32'h22222222, 0, 2, 0, 32'h0);

    // Request held high through a byte store; next load waits for IDLE.
    reqWrite = 1; reqSize = 2'b00; reqSigned = 0; reqAddr = 32'hA9; reqWdata = 32'h33;
    reqValid = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    @(posedge clk); #1;
    reqWrite = 0; reqSize = 2'b10; reqAddr = 32'hA8; reqWdata = 32'h0;
    exp_q.push_back({1'b0, 32'hACAC3380});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("held_busy_ready", {31'b0, reqReady}, 0);
      check("held_resp_valid", {31'b0, respValid}, {31'b0, k == 3});
    end
    @(posedge clk); #1;
    check("held_idle_ready", {31'b0, reqReady}, 1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(negedge clk);
    check("held_read_ready", {31'b0, reqReady}, 0);
    check("held_read_resp", {31'b0, respValid}, 0);
    @(negedge clk);
    check("held_load_resp", {31'b0, respValid}, 1);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
